// File: rtl/viu_pkg.sv
// Shared VIU TX-side types and widths.
package viu_pkg;

    localparam int AXI_NET_BITS   = 512;
    localparam int VIU_ROUTE_BITS = 14;

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } viu_arb_state_t;

endpackage

// File: rtl/viu_rr_pick.sv
// Rotating-priority picker: returns the first set request bit found by
// searching ptr+1, ptr+2, ... (mod N_REQ). ptr itself is checked last.
module viu_rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk the ring once starting just after ptr; the first hit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/viu_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the VIU TX egress stream among
// N_REQ requesters. The winner's route word is captured at grant time and held
// on m_route_out for the whole packet, because the tag inserter samples it on
// beat 0 and requesters may change s_route afterwards.
module viu_tx_arbiter
    import viu_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = AXI_NET_BITS,
    parameter int ROUTE_BITS = VIU_ROUTE_BITS,
    localparam int IDX_W     = $clog2(N_REQ),
    localparam int KEEP_W    = DATA_WIDTH / 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [N_REQ-1:0]            req_en,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_REQ*KEEP_W-1:0]     s_axis_tkeep,
    input  logic [N_REQ-1:0]            s_axis_tlast,
    input  logic [N_REQ-1:0]            s_axis_tvalid,
    output logic [N_REQ-1:0]            s_axis_tready,
    input  logic [N_REQ*ROUTE_BITS-1:0] s_route,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_W-1:0]           m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [ROUTE_BITS-1:0]       m_route_out,
    output logic [IDX_W-1:0]            gnt_id,
    output logic                        busy,
    output logic                        pkt_done,
    output logic [IDX_W-1:0]            pkt_done_id
);

    viu_arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ROUTE_BITS-1:0]  route_q, route_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IDX_W-1:0]       done_id_q, done_id_d;

    logic [N_REQ-1:0]       cand;
    logic                   pick_any;
    logic [IDX_W-1:0]       pick_idx;
    logic                   last_hs;

    // Only enabled requesters with a beat on offer compete.
    assign cand = s_axis_tvalid & req_en;

    viu_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (cand),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Granted stream pass-through; nothing moves while idle. tready depends
    // only on the registered grant and downstream tready, never on tvalid.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state_q == ST_PKT) begin
            m_axis_tdata         = s_axis_tdata[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep         = s_axis_tkeep[int'(gnt_q)*KEEP_W +: KEEP_W];
            m_axis_tlast         = s_axis_tlast[gnt_q];
            m_axis_tvalid        = s_axis_tvalid[gnt_q];
            s_axis_tready[gnt_q] = m_axis_tready;
        end
    end

    assign last_hs = (state_q == ST_PKT) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Next-state logic: grant on an idle cycle, release on the final handshake.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        route_d   = route_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    route_d = s_route[int'(pick_idx)*ROUTE_BITS +: ROUTE_BITS];
                    busy_d  = 1'b1;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                if (last_hs) begin
                    rr_ptr_d  = gnt_q;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = gnt_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and grant registers; rr_ptr starts at N_REQ-1 so requester 0 leads.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= IDX_W'(N_REQ - 1);
            route_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            route_q   <= route_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign m_route_out = route_q;
    assign gnt_id      = gnt_q;
    assign busy        = busy_q;
    assign pkt_done    = done_q;
    assign pkt_done_id = done_id_q;

endmodule

// File: tb/tb_viu_tx_arbiter.sv
// Directed bench for viu_tx_arbiter: per-requester packet sources, a beat
// monitor with hand-written expected grant order, an arbitration vector table
// and hand-written sequences for back-pressure, enable changes and reset.
module tb_viu_tx_arbiter;
    import viu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int RB = 14;
    localparam int IW = 2;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    req_en;
    logic [N*DW-1:0] s_axis_tdata;
    logic [N*KW-1:0] s_axis_tkeep;
    logic [N-1:0]    s_axis_tlast;
    logic [N-1:0]    s_axis_tvalid;
    logic [N-1:0]    s_axis_tready;
    logic [N*RB-1:0] s_route;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [RB-1:0]   m_route_out;
    logic [IW-1:0]   gnt_id;
    logic            busy;
    logic            pkt_done;
    logic [IW-1:0]   pkt_done_id;

    always #5 aclk = ~aclk;

    viu_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ROUTE_BITS(RB)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req_en        (req_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_route       (s_route),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_route_out   (m_route_out),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .pkt_done      (pkt_done),
        .pkt_done_id   (pkt_done_id)
    );

    int checks = 0;
    int errors = 0;

    // sources
    int   src_npk[N];
    int   src_len[N];
    int   src_beat[N];
    int   src_pkt[N];
    logic keep_full;
    logic route_chg;
    logic tready_toggle;

    // monitor
    int            exp_q[$];
    int            mon_pkt[N];
    int            done_cnt[N];
    int            mon_req;
    int            mon_beat;
    logic          mon_act;
    int            done_total;
    int            pulse_total;
    logic          done_pend;
    int            done_pend_id;
    logic [RB-1:0] last_route;
    logic          gap_chk;
    logic          have_last;
    int            cyc;
    int            last_cyc;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          rst_chk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] vld;
        int         prime;
        int         exp;
    } arb_vec_t;

    arb_vec_t tbl[10];

    function automatic logic [DW-1:0] mkdata(int i, int p, int b);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i * 4096 + p * 256 + b);
        return {16{w}};
    endfunction

    function automatic logic [KW-1:0] mkkeep(int i, int p, int b);
        if (keep_full) return 64'hFFFF_FFFF_FFFF_FFFF;
        return 64'hA5A5_0000_0000_0000 | 64'(i * 4096 + p * 256 + b);
    endfunction

    function automatic logic [RB-1:0] mkroute(int i, int p);
        return RB'(32'h1000 + i * 64 + p * 4 + 1);
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]           = (src_npk[i] > 0);
            s_axis_tdata[i*DW +: DW]   = mkdata(i, src_pkt[i], src_beat[i]);
            s_axis_tkeep[i*KW +: KW]   = mkkeep(i, src_pkt[i], src_beat[i]);
            s_axis_tlast[i]            = (src_beat[i] == src_len[i] - 1);
            s_route[i*RB +: RB]        = (route_chg && src_beat[i] != 0) ? ~mkroute(i, src_pkt[i])
                                                                        : mkroute(i, src_pkt[i]);
        end
        m_axis_tready = tready_toggle ? ~m_axis_tready : 1'b1;
    endtask

    task automatic mon_beat_step();
        if (!mon_act) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: grant %0d started a packet, none required", gnt_id);
                mon_req = int'(gnt_id);
            end else begin
                mon_req = exp_q.pop_front();
            end
            mon_act  = 1'b1;
            mon_beat = 0;
            if (gap_chk && have_last) chk("bubble_gap", DW'(cyc - last_cyc), 2);
        end
        chk("beat_gnt_id", gnt_id, mon_req);
        chk("beat_tdata", m_axis_tdata, mkdata(mon_req, mon_pkt[mon_req], mon_beat));
        chk("beat_tkeep", m_axis_tkeep, mkkeep(mon_req, mon_pkt[mon_req], mon_beat));
        chk("beat_route", m_route_out, mkroute(mon_req, mon_pkt[mon_req]));
        chk("beat_tlast", m_axis_tlast, (mon_beat == src_len[mon_req] - 1));
        if (mon_beat == src_len[mon_req] - 1) begin
            last_route   = mkroute(mon_req, mon_pkt[mon_req]);
            mon_pkt[mon_req]++;
            done_cnt[mon_req]++;
            done_total++;
            done_pend    = 1'b1;
            done_pend_id = mon_req;
            mon_act      = 1'b0;
            last_cyc     = cyc;
            have_last    = 1'b1;
        end else begin
            mon_beat++;
        end
    endtask

    task automatic cycle();
        logic [N-1:0] hs;
        @(negedge aclk);
        cyc++;
        if (rst_chk) begin
            chk("rst_mid_tvalid", m_axis_tvalid, 0);
            chk("rst_mid_busy", busy, 0);
            rst_chk = 1'b0;
        end
        if (pkt_done) pulse_total++;
        chk("pkt_done", pkt_done, done_pend);
        if (done_pend) begin
            chk("pkt_done_id", pkt_done_id, done_pend_id);
            chk("route_idle_hold", m_route_out, last_route);
        end
        done_pend = 1'b0;
        if (prev_stall) begin
            chk("stall_tvalid", m_axis_tvalid, 1);
            chk("stall_tdata", m_axis_tdata, prev_data);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) mon_beat_step();
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_pkt[i]++;
                    src_npk[i]--;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic run_pkts(int target, int budget);
        int n;
        n = 0;
        while (done_total < target && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (done_total < target) begin
            errors++;
            $display("FAIL pkt_timeout: got %0d packets, required %0d", done_total, target);
        end
    endtask

    task automatic rst_dut();
        aresetn       = 1'b0;
        tready_toggle = 1'b0;
        keep_full     = 1'b0;
        route_chg     = 1'b0;
        gap_chk       = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_npk[i]  = 0;
            src_len[i]  = 0;
            src_beat[i] = 0;
            src_pkt[i]  = 0;
            mon_pkt[i]  = 0;
            done_cnt[i] = 0;
        end
        exp_q.delete();
        mon_act     = 1'b0;
        mon_beat    = 0;
        done_total  = 0;
        pulse_total = 0;
        done_pend   = 1'b0;
        prev_stall  = 1'b0;
        have_last   = 1'b0;
        rst_chk     = 1'b0;
        drive();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_route", m_route_out, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_done_id", pkt_done_id, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        tbl[0] = '{en: 4'hF,    vld: 4'b0101, prime: -1, exp: 0};
        tbl[1] = '{en: 4'hF,    vld: 4'b1111, prime: 0,  exp: 1};
        tbl[2] = '{en: 4'hF,    vld: 4'b1001, prime: 0,  exp: 3};
        tbl[3] = '{en: 4'hF,    vld: 4'b1111, prime: 3,  exp: 0};
        tbl[4] = '{en: 4'b1011, vld: 4'b0100, prime: -1, exp: -1};
        tbl[5] = '{en: 4'b1110, vld: 4'b0011, prime: -1, exp: 1};
        tbl[6] = '{en: 4'hF,    vld: 4'b0001, prime: 0,  exp: 0};
        tbl[7] = '{en: 4'h0,    vld: 4'b1111, prime: -1, exp: -1};
        tbl[8] = '{en: 4'hF,    vld: 4'b0110, prime: 2,  exp: 1};
        tbl[9] = '{en: 4'b0111, vld: 4'b1100, prime: 1,  exp: 2};

        aresetn       = 1'b0;
        req_en        = '0;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tvalid = '0;
        s_route       = '0;
        cyc           = 0;
        last_cyc      = 0;
        mon_req       = 0;
        done_pend_id  = 0;
        last_route    = '0;
        prev_data     = '0;

        // Arbitration vectors: optional priming packet sets rr_ptr, then one decision.
        for (int v = 0; v < 10; v++) begin
            rst_dut();
            if (tbl[v].prime >= 0) begin
                req_en                 = 4'hF;
                src_len[tbl[v].prime]  = 1;
                src_npk[tbl[v].prime]  = 1;
                exp_q.push_back(tbl[v].prime);
                drive();
                run_pkts(1, 10);
            end
            base   = done_total;
            req_en = tbl[v].en;
            for (int i = 0; i < N; i++) begin
                if (tbl[v].vld[i]) begin
                    src_len[i] = 1;
                    src_npk[i] = 1;
                end
            end
            if (tbl[v].exp >= 0) exp_q.push_back(tbl[v].exp);
            drive();
            cycle();
            chk("tbl_busy", busy, (tbl[v].exp >= 0));
            if (tbl[v].exp >= 0) begin
                chk("tbl_gnt_id", gnt_id, tbl[v].exp);
                run_pkts(base + 1, 10);
            end else begin
                repeat (3) begin
                    cycle();
                    chk("tbl_idle_busy", busy, 0);
                    chk("tbl_idle_tready", s_axis_tready, 0);
                end
            end
        end

        // Requesters 0 and 2, 3-beat packets: 0 first, then 2; one-cycle grant latency.
        rst_dut();
        req_en     = 4'hF;
        src_len[0] = 3;
        src_npk[0] = 1;
        src_len[2] = 3;
        src_npk[2] = 1;
        gap_chk    = 1'b1;
        exp_q      = '{0, 2};
        drive();
        #1;
        chk("idle_no_tready", s_axis_tready, 0);
        chk("idle_no_tvalid", m_axis_tvalid, 0);
        cycle();
        chk("lat_busy", busy, 1);
        chk("lat_gnt", gnt_id, 0);
        chk("lat_tvalid", m_axis_tvalid, 1);
        chk("lat_route", m_route_out, mkroute(0, 0));
        chk("lat_tready", s_axis_tready, 4'b0001);
        run_pkts(2, 30);
        cycle();

        // All four continuously valid, 3-beat packets: strict rotation with bubbles.
        rst_dut();
        req_en  = 4'hF;
        gap_chk = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 3;
            src_npk[i] = 2;
        end
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        drive();
        run_pkts(8, 60);
        cycle();

        // Requester 1, 5 beats, toggling downstream tready, route changes after beat 0.
        rst_dut();
        req_en        = 4'hF;
        src_len[1]    = 5;
        src_npk[1]    = 1;
        route_chg     = 1'b1;
        tready_toggle = 1'b1;
        exp_q         = '{1};
        drive();
        run_pkts(1, 40);
        repeat (4) cycle();
        chk("bp_pulses", pulse_total, 1);
        chk("bp_done_cnt1", done_cnt[1], 1);

        // Requester 2 masked; requester 1 disabled during its own packet.
        rst_dut();
        req_en = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            src_len[i] = 4;
            src_npk[i] = 2;
        end
        exp_q = '{0, 1, 0};
        drive();
        n = 0;
        while (done_total < 3 && n < 60) begin
            cycle();
            if (mon_act && mon_req == 1 && mon_beat >= 1) req_en[1] = 1'b0;
            n++;
        end
        chk("en_pkts", done_total, 3);
        repeat (4) begin
            cycle();
            chk("en_idle_busy", busy, 0);
            chk("en_idle_tready", s_axis_tready, 0);
        end
        chk("en_req1_cnt", done_cnt[1], 1);
        chk("en_req2_cnt", done_cnt[2], 0);

        // Single-beat packets alternating 0 and 3 with full tkeep: two cycles each.
        rst_dut();
        req_en     = 4'hF;
        keep_full  = 1'b1;
        gap_chk    = 1'b1;
        src_len[0] = 1;
        src_npk[0] = 3;
        src_len[3] = 1;
        src_npk[3] = 3;
        exp_q      = '{0, 3, 0, 3, 0, 3};
        drive();
        run_pkts(6, 40);
        cycle();

        // Reset on beat 2 of requester 1's packet after requester 0 completed one.
        rst_dut();
        req_en     = 4'hF;
        src_len[0] = 4;
        src_npk[0] = 2;
        src_len[1] = 4;
        src_npk[1] = 2;
        exp_q      = '{0, 1, 0, 1};
        drive();
        n = 0;
        while (!(mon_act && mon_req == 1 && mon_beat == 2) && n < 40) begin
            cycle();
            n++;
        end
        chk("rst_reach_beat2", (mon_act && mon_req == 1 && mon_beat == 2), 1);
        aresetn = 1'b0;
        cycle();
        aresetn     = 1'b1;
        src_beat[1] = 0;
        mon_act     = 1'b0;
        mon_beat    = 0;
        done_pend   = 1'b0;
        prev_stall  = 1'b0;
        have_last   = 1'b0;
        rst_chk     = 1'b1;
        drive();
        run_pkts(3, 40);
        cycle();
        chk("rst_done_cnt0", done_cnt[0], 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
